// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding (also used by the
// decoder) and the sequencer state encoding.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative one-bit-per-cycle multiply (shift-add) / divide (restoring) unit
// with architectural HI/LO registers; operands run as magnitudes, sign fixed at the end.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_w,
  input  logic             lo_w,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mdu_pkg::*;

  localparam int unsigned ACC_W = 2 * WIDTH;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return WIDTH'(~x + WIDTH'(1));
  endfunction

  function automatic logic [ACC_W-1:0] neg_acc(input logic [ACC_W-1:0] x);
    return ACC_W'(~x + ACC_W'(1));
  endfunction

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_src_a;
  logic [WIDTH-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_b_zero;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [ACC_W-1:0]   w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_div_ge;
  logic [ACC_W-1:0]   w_div_next;
  logic [ACC_W-1:0]   w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

  // Operand magnitudes and signs at the accepting edge
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & src_a[WIDTH-1];
  assign w_b_neg  = w_signed & src_b[WIDTH-1];
  assign w_mag_a  = w_a_neg ? neg_w(src_a) : src_a;
  assign w_mag_b  = w_b_neg ? neg_w(src_b) : src_b;

  // Multiply step: {hi_part, multiplier} accumulator, add then shift right
  assign w_mul_sum  = {1'b0, r_acc[ACC_W-1:WIDTH]} + {1'b0, r_b};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[ACC_W-1:1]};

  // Divide step: {remainder, quotient} accumulator, shift left and trial subtract
  assign w_div_shift = r_acc[ACC_W-1:WIDTH-1];
  assign w_div_ge    = w_div_shift >= {1'b0, r_b};
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;
  assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_div_ge};

  assign w_prod = r_neg_res ? neg_acc(r_acc) : r_acc;

  // Final sign correction and divide-by-zero override
  always_comb begin
    w_res_hi = w_prod[ACC_W-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_b_zero) begin
        w_res_hi = r_src_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_neg_rem ? neg_w(r_acc[ACC_W-1:WIDTH]) : r_acc[ACC_W-1:WIDTH];
        w_res_lo = r_neg_res ? neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_CALC;
      ST_CALC: if (r_cnt == WIDTH'(WIDTH - 1)) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_b       <= '0;
      r_src_a   <= '0;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_b_zero  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_is_div  <= op[1];
            r_acc     <= op[1] ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
            r_b       <= op[1] ? w_mag_b : w_mag_a;
            r_src_a   <= src_a;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_b_zero  <= (src_b == '0);
            r_cnt     <= '0;
            r_busy    <= 1'b1;
          end else begin
            if (hi_w) r_hi <= wr_data;
            if (lo_w) r_lo <= wr_data;
          end
        end
        ST_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + WIDTH'(1);
        end
        ST_FIX: begin
          r_hi   <= w_res_hi;
          r_lo   <= w_res_lo;
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_dbz  <= r_is_div & r_b_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32).
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         hi_w;
  logic         lo_w;
  logic [W-1:0] wr_data;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_w(hi_w), .lo_w(lo_w), .wr_data(wr_data), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_checks++; if (hi !== 32'h0) $display("FAIL reset_hi got %h exp 0", hi); else n_pass++;
    n_checks++; if (lo !== 32'h0) $display("FAIL reset_lo got %h exp 0", lo); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b exp 0", div_by_zero); else n_pass++;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_mult();
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    src_a = 32'h0; src_b = 32'h0;
    n_checks++; if (busy !== 1'b1) $display("FAIL mult_busy_e0 got %b exp 1", busy); else n_pass++;
    step(W);
    n_checks++; if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL mult_fix_cycle got busy=%b done=%b exp busy=1 done=0", busy, done); else n_pass++;
    step(1);
    n_checks++; if (done !== 1'b1) $display("FAIL mult_done got %b exp 1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mult_busy_done got %b exp 0", busy); else n_pass++;
    n_checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h exp ffffffff", hi); else n_pass++;
    n_checks++; if (lo !== 32'hFFFF_FFF1) $display("FAIL mult_lo got %h exp fffffff1", lo); else n_pass++;
    n_checks++; if (div_by_zero !== 1'b0) $display("FAIL mult_dbz got %b exp 0", div_by_zero); else n_pass++;
    step(1);
    n_checks++; if (done !== 1'b0) $display("FAIL mult_done_pulse got %b exp 0", done); else n_pass++;
  endtask

  task automatic test_multu();
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(W + 1);
    n_checks++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h exp fffffffe", hi); else n_pass++;
    n_checks++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo got %h exp 00000001", lo); else n_pass++;
    step(1);
  endtask

  task automatic test_div();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    step(W + 1);
    n_checks++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo got %h exp fffffffd", lo); else n_pass++;
    n_checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi got %h exp ffffffff", hi); else n_pass++;
    step(1);
    issue(OP_DIVU, 32'd100, 32'd0);
    step(W);
    n_checks++; if (done !== 1'b0) $display("FAIL dbz_early_done got %b exp 0", done); else n_pass++;
    step(1);
    n_checks++; if (done !== 1'b1 || div_by_zero !== 1'b1)
      $display("FAIL dbz_flag got done=%b dbz=%b exp 1 1", done, div_by_zero); else n_pass++;
    n_checks++; if (lo !== 32'hFFFF_FFFF) $display("FAIL dbz_lo got %h exp ffffffff", lo); else n_pass++;
    n_checks++; if (hi !== 32'h0000_0064) $display("FAIL dbz_hi got %h exp 00000064", hi); else n_pass++;
    step(1);
    n_checks++; if (div_by_zero !== 1'b0) $display("FAIL dbz_clear got %b exp 0", div_by_zero); else n_pass++;
  endtask

  task automatic test_ignore_and_mt();
    issue(OP_MULTU, 32'd3, 32'd7);
    step(5);
    op = OP_DIV; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
    hi_w = 1'b1; wr_data = 32'h1234;
    step(1);
    start = 1'b0; hi_w = 1'b0;
    step(W + 1 - 6);
    n_checks++; if (done !== 1'b1) $display("FAIL ign_done got %b exp 1", done); else n_pass++;
    n_checks++; if (lo !== 32'd21) $display("FAIL ign_lo got %h exp 00000015", lo); else n_pass++;
    n_checks++; if (hi !== 32'd0) $display("FAIL ign_hi got %h exp 0", hi); else n_pass++;
    step(1);
    hi_w = 1'b1; wr_data = 32'h1234;
    step(1);
    hi_w = 1'b0;
    n_checks++; if (hi !== 32'h1234) $display("FAIL mthi got %h exp 00001234", hi); else n_pass++;
    n_checks++; if (lo !== 32'd21) $display("FAIL mthi_lo got %h exp 00000015", lo); else n_pass++;
    lo_w = 1'b1; wr_data = 32'hDEAD;
    issue(OP_MULTU, 32'd2, 32'd3);
    lo_w = 1'b0;
    n_checks++; if (lo !== 32'd21 || busy !== 1'b1)
      $display("FAIL start_lo_w got lo=%h busy=%b exp lo=00000015 busy=1", lo, busy); else n_pass++;
    step(W + 1);
    n_checks++; if (lo !== 32'd6 || hi !== 32'd0)
      $display("FAIL start_lo_w_res got hi=%h lo=%h exp 0 6", hi, lo); else n_pass++;
    step(1);
  endtask

  task automatic test_back_to_back();
    issue(OP_MULTU, 32'd6, 32'd7);
    step(W + 1);
    n_checks++; if (lo !== 32'd42) $display("FAIL b2b_first got %h exp 0000002a", lo); else n_pass++;
    op = OP_DIV; src_a = 32'h8000_0000; src_b = 32'hFFFF_FFFF; start = 1'b1;
    step(1);
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_done_start got busy=%b exp 0", busy); else n_pass++;
    step(1);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b exp 1", busy); else n_pass++;
    step(W + 1);
    n_checks++; if (done !== 1'b1) $display("FAIL minneg1_done got %b exp 1", done); else n_pass++;
    n_checks++; if (lo !== 32'h8000_0000) $display("FAIL minneg1_lo got %h exp 80000000", lo); else n_pass++;
    n_checks++; if (hi !== 32'h0) $display("FAIL minneg1_hi got %h exp 0", hi); else n_pass++;
    n_checks++; if (div_by_zero !== 1'b0) $display("FAIL minneg1_dbz got %b exp 0", div_by_zero); else n_pass++;
    step(1);
  endtask

  task automatic test_reset_mid();
    int done_seen;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    step(9);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (hi !== 32'h0 || lo !== 32'h0)
      $display("FAIL rmid_hilo got hi=%h lo=%h exp 0 0", hi, lo); else n_pass++;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_seen++;
      step(1);
    end
    n_checks++; if (done_seen !== 0) $display("FAIL rmid_no_done got %0d pulses exp 0", done_seen); else n_pass++;
    issue(OP_DIVU, 32'd9, 32'd4);
    step(W + 1);
    n_checks++; if (done !== 1'b1) $display("FAIL rmid_divu_done got %b exp 1", done); else n_pass++;
    n_checks++; if (lo !== 32'd2 || hi !== 32'd1)
      $display("FAIL rmid_divu got hi=%h lo=%h exp 1 2", hi, lo); else n_pass++;
    step(2);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hi_w = 1'b0; lo_w = 1'b0; wr_data = '0;
    #1;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_ignore_and_mt();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, attached to the execute stage of the pipelined CPU. It accepts one MULT/MULTU/DIV/DIVU request at a time and runs a one-bit-per-cycle shift-add multiply or restoring divide. Results go to HI/LO. The pipeline's hazard logic stalls MFHI/MFLO consumers while `busy` is high.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `src_a`  in  WIDTH  multiplicand or dividend.
- `src_b`  in  WIDTH  multiplier or divisor.
- `hi_w`  in  1  MTHI strobe.
- `lo_w`  in  1  MTLO strobe.
- `wr_data`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse: HI/LO just updated by an operation.
- `div_by_zero`  out  1  qualifies `done`; divisor was zero.
- `hi`  out  WIDTH  HI register: product upper half, or remainder.
- `lo`  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE + `start`: latch `op`, operand magnitudes (signed ops only) and result sign; clear the `WIDTH`-wide iteration counter; go to CALC.
- CALC: one iteration per cycle over a 2·`WIDTH` accumulator. After `WIDTH` iterations, go to FIX.
  - Multiply: conditional add of the multiplicand, then shift right.
  - Divide: shift left, trial subtract, restore if negative.
- FIX: apply sign correction, write `hi`/`lo`, register `done`=1, go to DONE.
  - Product is negated if the operand signs differ.
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
- DONE: `done` is high for this cycle only. Return to IDLE; a `start` here is ignored.
- Signed MIN/−1: quotient = MIN, remainder = 0; `div_by_zero` stays 0.
- Divide by zero, signed or unsigned:
  - CALC still runs the full `WIDTH` cycles.
  - `lo` = all ones, `hi` = dividend.
  - `div_by_zero`=1 in the `done` cycle.
- `hi_w`/`lo_w` act only in IDLE: `hi`/`lo` take `wr_data` at the edge.
  - Both strobes together write both registers.
  - `start` in the same cycle wins and the MT write is discarded.
  - MT strobes in CALC/FIX/DONE are discarded.
- `start` outside IDLE is discarded; there is no queue.
- Operands are sampled only at the accepting edge; later changes on `src_a`/`src_b` have no effect.

## Timing
- Reset (`rst_n`=0 at an edge), including mid-operation:
  - state = IDLE;
  - `hi`=`lo`=0;
  - `busy`=`done`=`div_by_zero`=0;
  - the partial result is discarded.
- Accepting edge E0: `busy` rises after E0.
- CALC occupies edges E1…E`WIDTH`; FIX is at edge E(`WIDTH`+1).
- `hi`/`lo` update and `done` rises after E(`WIDTH`+1). Latency is `WIDTH`+1 edges, i.e. 33 for `WIDTH`=32.
- `busy` is high from after E0 through the FIX cycle. It is low whenever `done` is high.
- Back-to-back: the earliest next accept is the edge after the DONE cycle, giving a throughput of `WIDTH`+3 cycles per operation.
- MT write latency: `hi`/`lo` update at the edge where the strobe is sampled.
- All outputs come straight from registers; there are no combinational input-to-output paths.

## Structure
- Shared package `mdu_pkg` holds:
  - the `op` encoding constants (MULT/MULTU/DIV/DIVU), also used by the decoder;
  - the state encoding typedef.
- Single module, no sub-modules. Negate/absolute-value logic is local functions.
- The hazard unit stalls on `busy` and any MFHI/MFLO in decode. This block does no stall generation itself.

## Test plan
- MULT, `src_a`=0xFFFFFFFD, `src_b`=5 -> after 33 edges `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; `done` one cycle; `busy` low in that cycle.
- MULTU, 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Signed division, both cases:
  - DIV, −7 (0xFFFFFFF9) / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV, 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU, 100 / 0 -> `lo`=0xFFFFFFFF, `hi`=0x64; `div_by_zero`=1 with `done`.
- Second `start` with new operands 5 cycles into an operation -> ignored; the first result is unchanged. `hi_w` with 0x1234 during CALC -> discarded. `hi_w` in IDLE -> `hi`=0x1234 next edge. `start` plus `lo_w` together in IDLE -> `lo_w` discarded.
- Reset mid-operation: `rst_n`=0 at edge 10 of a MULT -> `busy`=0, `hi`=`lo`=0, no `done`. A new DIVU 9/4 issued after reset -> `lo`=2, `hi`=1 after 33 edges.
